dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Shares the single-port 19-bit data memory between two requesters. Port 0 is the EXE-stage load/store path. Port 1 is the auxiliary block-op engine, which handles FFT, encrypt and decrypt bulk transfers. The block sits between the EXE_WB stage's memory-address and write-data muxes and data_memory. It arbitrates round-robin with a bounded lock for bursts, drives the memory port, returns registered read data and raises a pipeline stall when port 0 is not served.

Parameters:
AW, 8, memory address width
DW, 19, memory data width
MAX_LOCK, 8, max consecutive grants a locked owner may hold while the other port requests (range 1..255)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
req0  in  1  port 0 access request (EXE stage)
we0  in  1  port 0 write enable (1 = store, 0 = load)
addr0  in  AW  port 0 address
wd0  in  DW  port 0 write data
req1  in  1  port 1 access request (block-op engine)
we1  in  1  port 1 write enable
addr1  in  AW  port 1 address
wd1  in  DW  port 1 write data
lock1  in  1  port 1 burst lock; holds ownership while req1 stays high
gnt0  out  1  port 0 access performed this cycle
gnt1  out  1  port 1 access performed this cycle
rvalid0  out  1  port 0 read data valid (one cycle after a granted load)
rvalid1  out  1  port 1 read data valid
rdata  out  DW  registered read data, shared by both ports
stall  out  1  req0 & ~gnt0; freezes the pipeline front end
mem_we  out  1  data memory write enable
mem_addr  out  AW  data memory address
mem_wd  out  DW  data memory write data
mem_rd  in  DW  data memory combinational read data
conflict_cnt  out  8  saturating count of cycles where both ports requested

Behaviour:
- Reset (rst=1 at clock edge):
  - rvalid0, rvalid1 and rdata go to 0; conflict_cnt and lock counter go to 0.
  - Priority pointer last goes to 1, so port 0 wins the first tie.
  - While rst is high, gnt0, gnt1 and mem_we are forced to 0 and stall to req0.
- Grant is combinational from the current requests and registered state. At most one grant per cycle.
  - Only one port requesting: that port is granted.
  - Both requesting, no lock in force: the port not equal to last is granted (round-robin).
  - Lock in force: lock1 & req1 & owner==1 & lock_cnt < MAX_LOCK. Port 1 is granted even when req0 is high.
  - When lock_cnt reaches MAX_LOCK with req0 pending, port 0 receives exactly one grant. The lock then resumes if lock1 & req1 are still high, with lock_cnt restarted at 0.
- lock_cnt:
  - Increments on each gnt1 cycle while req0 is high and lock is held.
  - Clears on any gnt0, on lock1=0, or on req1=0.
  - Saturates at MAX_LOCK.
- Memory drive:
  - On a granted cycle, mem_addr and mem_wd come from the granted port, and mem_we = we of the granted port.
  - With no grant, mem_we=0 and mem_addr/mem_wd hold port 0 values. This is don't-care but must be deterministic.
- Read return:
  - A granted load (we=0) captures mem_rd into rdata at the next edge and pulses the matching rvalid for exactly 1 cycle.
  - A granted store produces no rvalid. rdata holds its last value.
- last updates to the granted port index on every grant and is unchanged on idle cycles.
- stall = req0 & ~gnt0, combinational. It is never high when req0=0.
- conflict_cnt increments on each cycle with req0 & req1 (rst=0). It saturates at 255 and never wraps.
- A request dropped before grant is simply forgotten; there is no queueing.
- Simultaneous rst and requests: rst wins and no memory write occurs.
- Reset mid-lock clears ownership; the next cycle arbitrates fresh with port 0 preferred.

Test Plan:
- Reset then req0 load addr0=0x10, with mem model holding 0x12345 there -> gnt0=1 same cycle; next cycle rvalid0=1 and rdata=0x12345; stall=0.
- req0 & req1 both high every cycle, no lock, 6 cycles -> grants alternate 0,1,0,1,0,1; stall=1 on cycles 2,4,6; conflict_cnt=6.
- Port 1 store addr1=0x20 wd1=0x7FFFF -> mem_we=1, mem_addr=0x20, mem_wd=0x7FFFF for one cycle; no rvalid; a following port 0 load of 0x20 returns 0x7FFFF.
- lock1=1, req1 held high, req0 raised while port 1 owns, MAX_LOCK=8 -> 8 consecutive gnt1 with stall=1, then one gnt0, then gnt1 resumes.
- Assert rst during a locked burst -> next cycle gnt1=0 with mem_we=0; after release with both requesting, gnt0=1 first.
- Hold both requests 300 cycles -> conflict_cnt reaches 255 and stays there.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the EXE-stage
// load/store path (port 0) and the block-op engine (port 1). Round-robin
// arbitration with a bounded burst lock for port 1, registered read return,
// and a pipeline stall whenever port 0 asks but is not served.
module dmem_arbiter #(
    parameter int unsigned AW       = 8,
    parameter int unsigned DW       = 19,
    parameter int unsigned MAX_LOCK = 8
) (
    input  logic          clk,
    input  logic          rst,
    // port 0: EXE stage
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wd0,
    // port 1: block-op engine
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wd1,
    input  logic          lock1,
    // grants and read return
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          stall,
    // data memory port
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd,
    // statistics
    output logic [7:0]    conflict_cnt
);

    localparam logic [7:0] LOCK_LIMIT = 8'(MAX_LOCK);
    localparam logic [7:0] CNT_MAX    = 8'hFF;

    // Registered state
    logic          last_q,     last_d;      // port granted most recently
    logic          owner_q,    owner_d;     // port 1 holds burst ownership
    logic [7:0]    lock_cnt_q, lock_cnt_d;  // locked grants taken while port 0 waited
    logic [7:0]    conflict_q, conflict_d;
    logic          rvalid0_q,  rvalid0_d;
    logic          rvalid1_q,  rvalid1_d;
    logic [DW-1:0] rdata_q,    rdata_d;

    // Combinational arbitration results
    logic lock_active;
    logic grant0;
    logic grant1;

    // Arbitration: burst lock first, then round-robin on ties, else the lone requester
    always_comb begin
        // NOTE: every signal assigned in an always_comb gets a default first;
        // a path that leaves one unassigned infers a latch.
        grant0      = 1'b0;
        grant1      = 1'b0;
        lock_active = lock1 & req1 & owner_q & (lock_cnt_q < LOCK_LIMIT);
        if (!rst) begin
            if (lock_active) begin
                grant1 = 1'b1;
            end else if (req0 && req1) begin
                // last_q==1 means port 1 went last, so port 0 wins the tie
                if (last_q) grant0 = 1'b1;
                else        grant1 = 1'b1;
            end else if (req0) begin
                grant0 = 1'b1;
            end else if (req1) begin
                grant1 = 1'b1;
            end
        end
    end

    // Memory port mux: granted port drives; idle cycles present port 0 with no write
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = addr0;
        mem_wd   = wd0;
        if (grant1) begin
            mem_we   = we1;
            mem_addr = addr1;
            mem_wd   = wd1;
        end else if (grant0) begin
            mem_we   = we0;
        end
    end

    // Next-state for priority pointer, burst ownership and the lock counter
    always_comb begin
        last_d     = last_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        if (rst) begin
            last_d     = 1'b1;
            owner_d    = 1'b0;
            lock_cnt_d = '0;
        end else begin
            if (grant0 || grant1) begin
                last_d = grant1;
            end
            // Ownership follows the last grant; dropping req1 releases it
            if (grant0 || grant1) begin
                owner_d = grant1;
            end else if (!req1) begin
                owner_d = 1'b0;
            end
            // Count only grants that held port 0 off; any port 0 grant or
            // release of the burst restarts the budget
            if (grant0 || !lock1 || !req1) begin
                lock_cnt_d = '0;
            end else if (grant1 && req0 && lock_active) begin
                lock_cnt_d = lock_cnt_q + 8'd1;
            end
        end
    end

    // Next-state for read return and the conflict statistic
    always_comb begin
        rvalid0_d  = 1'b0;
        rvalid1_d  = 1'b0;
        rdata_d    = rdata_q;
        conflict_d = conflict_q;
        if (rst) begin
            rdata_d    = '0;
            conflict_d = '0;
        end else begin
            if (grant0 && !we0) begin
                rvalid0_d = 1'b1;
                rdata_d   = mem_rd;
            end else if (grant1 && !we1) begin
                rvalid1_d = 1'b1;
                rdata_d   = mem_rd;
            end
            if (req0 && req1 && (conflict_q != CNT_MAX)) begin
                conflict_d = conflict_q + 8'd1;
            end
        end
    end

    // State registers; reset is folded into the _d logic above
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples the pre-edge value of its neighbours.
        last_q     <= last_d;
        owner_q    <= owner_d;
        lock_cnt_q <= lock_cnt_d;
        conflict_q <= conflict_d;
        rvalid0_q  <= rvalid0_d;
        rvalid1_q  <= rvalid1_d;
        rdata_q    <= rdata_d;
    end

    assign gnt0         = grant0;
    assign gnt1         = grant1;
    assign stall        = req0 & ~grant0;
    assign rvalid0      = rvalid0_q;
    assign rvalid1      = rvalid1_q;
    assign rdata        = rdata_q;
    assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: memory model, read-return scoreboard and
// directed scenarios covering reset, round-robin, stores, burst lock,
// reset during a lock and conflict counter saturation.
module tb_dmem_arbiter;

    localparam int AW = 8;
    localparam int DW = 19;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, we0, req1, we1, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wd0, wd1;
    logic          gnt0, gnt1, rvalid0, rvalid1, stall, mem_we;
    logic [DW-1:0] rdata, mem_wd, mem_rd;
    logic [AW-1:0] mem_addr;
    logic [7:0]    conflict_cnt;

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wd0(wd0),
        .req1(req1), .we1(we1), .addr1(addr1), .wd1(wd1), .lock1(lock1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .stall(stall),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    // Data memory model: combinational read, write on the rising edge
    logic [DW-1:0] mem [256];
    assign mem_rd = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] = mem_wd;
    end

    typedef struct {
        logic          port;
        logic [DW-1:0] data;
    } rd_exp_t;

    rd_exp_t sb[$];
    int      n_tests = 0;
    int      n_fail  = 0;
    int      exp_conf = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_in(input logic r0, input logic w0, input logic [AW-1:0] a0,
                          input logic [DW-1:0] d0, input logic r1, input logic w1,
                          input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                          input logic l1);
        req0 = r0; we0 = w0; addr0 = a0; wd0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wd1 = d1; lock1 = l1;
    endtask

    // One clock cycle with inputs already applied after the falling edge:
    // check registered outputs against the scoreboard, check this cycle's
    // grant and memory drive against the intended grant, then advance.
    task automatic step(input string tag, input logic eg0, input logic eg1);
        rd_exp_t       e;
        logic          exp_we;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_wd;
        #2;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, ".rvalid0"}, {31'd0, rvalid0}, {31'd0, e.port == 1'b0});
            check({tag, ".rvalid1"}, {31'd0, rvalid1}, {31'd0, e.port == 1'b1});
            check({tag, ".rdata"}, {13'd0, rdata}, {13'd0, e.data});
        end else begin
            check({tag, ".rvalid0"}, {31'd0, rvalid0}, 32'd0);
            check({tag, ".rvalid1"}, {31'd0, rvalid1}, 32'd0);
        end
        check({tag, ".conf"}, {24'd0, conflict_cnt}, exp_conf);
        exp_we   = eg1 ? we1 : (eg0 ? we0 : 1'b0);
        exp_addr = eg1 ? addr1 : addr0;
        exp_wd   = eg1 ? wd1 : wd0;
        check({tag, ".gnt0"}, {31'd0, gnt0}, {31'd0, eg0});
        check({tag, ".gnt1"}, {31'd0, gnt1}, {31'd0, eg1});
        check({tag, ".stall"}, {31'd0, stall}, {31'd0, req0 & ~eg0});
        check({tag, ".mem_we"}, {31'd0, mem_we}, {31'd0, exp_we});
        if (eg0 || eg1) begin
            check({tag, ".mem_addr"}, {24'd0, mem_addr}, {24'd0, exp_addr});
            if (exp_we) check({tag, ".mem_wd"}, {13'd0, mem_wd}, {13'd0, exp_wd});
        end
        if (eg0 && !we0) sb.push_back('{port: 1'b0, data: mem[addr0]});
        if (eg1 && !we1) sb.push_back('{port: 1'b1, data: mem[addr1]});
        if (rst) begin
            sb.delete();
            exp_conf = 0;
        end else if (req0 && req1 && exp_conf < 255) begin
            exp_conf++;
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 19'(i * 3 + 1);
        mem[8'h10] = 19'h12345;
        rst = 1'b1;
        set_in(0, 0, 8'h00, '0, 0, 0, 8'h00, '0, 0);
        repeat (2) @(negedge clk);

        // Reset state
        rst = 1'b0;
        #2;
        check("rst.rvalid0", {31'd0, rvalid0}, 32'd0);
        check("rst.rvalid1", {31'd0, rvalid1}, 32'd0);
        check("rst.rdata", {13'd0, rdata}, 32'd0);
        check("rst.conf", {24'd0, conflict_cnt}, 32'd0);
        @(negedge clk);

        // Port 0 load from 0x10
        set_in(1, 0, 8'h10, '0, 0, 0, 8'h00, '0, 0);
        step("ld0", 1, 0);
        set_in(0, 0, 8'h00, '0, 0, 0, 8'h00, '0, 0);
        #2 check("ld0.rdata_const", {13'd0, rdata}, 32'h12345);
        step("ld0_ret", 0, 0);

        // Fresh reset, then six tied cycles alternate 0,1,0,1,0,1
        rst = 1'b1;
        step("rst2", 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_in(1, 0, 8'(i), '0, 1, 0, 8'(8'h40 + i), '0, 0);
            step("rr", (i % 2) == 0, (i % 2) == 1);
        end
        set_in(0, 0, 8'h00, '0, 0, 0, 8'h00, '0, 0);
        check("rr.conf6", {24'd0, conflict_cnt}, 32'd6);
        step("rr_ret", 0, 0);

        // Port 1 store, then port 0 reads it back
        set_in(0, 0, 8'h00, '0, 1, 1, 8'h20, 19'h7FFFF, 0);
        step("st1", 0, 1);
        set_in(1, 0, 8'h20, '0, 0, 0, 8'h00, '0, 0);
        step("st1_rd", 1, 0);
        set_in(0, 0, 8'h00, '0, 0, 0, 8'h00, '0, 0);
        #2 check("st1.rdata_const", {13'd0, rdata}, 32'h7FFFF);
        step("st1_ret", 0, 0);

        // Burst lock: port 1 owns, port 0 waits 8 grants, gets one, lock resumes
        set_in(0, 0, 8'h00, '0, 1, 0, 8'h80, '0, 1);
        step("lk_own", 0, 1);
        for (int i = 0; i < 8; i++) begin
            set_in(1, 0, 8'h05, '0, 1, 0, 8'(8'h81 + i), '0, 1);
            step("lk_hold", 0, 1);
        end
        set_in(1, 0, 8'h05, '0, 1, 0, 8'h90, '0, 1);
        step("lk_esc", 1, 0);
        step("lk_res", 0, 1);
        step("lk_res2", 0, 1);

        // Reset in the middle of a locked burst, with a port 1 store pending
        rst = 1'b1;
        set_in(1, 0, 8'h06, '0, 1, 1, 8'h91, 19'h55555, 1);
        step("lk_rst", 0, 0);
        rst = 1'b0;
        set_in(1, 0, 8'h06, '0, 1, 0, 8'h91, '0, 1);
        step("post_rst", 1, 0);
        step("post_rst1", 0, 1);
        check("post_rst.mem91", {13'd0, mem[8'h91]}, 32'(8'h91 * 3 + 1));

        // Conflict counter saturation over 300 tied cycles
        rst = 1'b1;
        set_in(0, 0, 8'h00, '0, 0, 0, 8'h00, '0, 0);
        step("rst3", 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 300; i++) begin
            set_in(1, 0, 8'(i), '0, 1, 0, 8'(255 - i), '0, 0);
            step("sat", (i % 2) == 0, (i % 2) == 1);
        end
        set_in(0, 0, 8'h00, '0, 0, 0, 8'h00, '0, 0);
        check("sat.conf255", {24'd0, conflict_cnt}, 32'd255);
        step("sat_ret", 0, 0);
        check("sat.hold", {24'd0, conflict_cnt}, 32'd255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
